// File: rtl/flash_ctrl.sv
// Flash command sequencer: turns one read / page-program / sector-erase request
// into WREN, main command and RDSR status polling for a single SPI driver.
module flash_ctrl #(
  parameter logic [15:0] P_POLL_MAX = 16'd50000,
  parameter logic [7:0]  P_CMD_READ = 8'h03,
  parameter logic [7:0]  P_CMD_PP   = 8'h02,
  parameter logic [7:0]  P_CMD_SE   = 8'h20,
  parameter logic [7:0]  P_CMD_WREN = 8'h06,
  parameter logic [7:0]  P_CMD_RDSR = 8'h05
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  input  logic [1:0]  i_cmd_type,
  input  logic [23:0] i_cmd_addr,
  input  logic [8:0]  i_cmd_len,
  output logic        o_cmd_ready,
  output logic        o_done,
  output logic        o_err,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_req,
  output logic [7:0]  o_rd_data,
  output logic        o_rd_valid,
  output logic [31:0] o_spi_op_data,
  output logic        o_spi_op_len,
  output logic [1:0]  o_spi_op_type,
  output logic        o_spi_op_valid,
  input  logic        i_spi_op_ready,
  output logic [8:0]  o_spi_rw_len,
  input  logic        i_spi_write_req,
  output logic [7:0]  o_spi_write_data,
  input  logic [7:0]  i_spi_read_data,
  input  logic        i_spi_read_valid
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WREN = 3'd1;
  localparam logic [2:0] S_MAIN = 3'd2;
  localparam logic [2:0] S_POLL = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  localparam logic [1:0] T_READ = 2'd0;
  localparam logic [1:0] T_PP   = 2'd1;
  localparam logic [1:0] T_SE   = 2'd2;

  logic [2:0]  state_q, state_d;
  logic        wait_q, wait_d;      // 0 = ISSUE substate, 1 = WAIT substate
  logic [1:0]  hold_q, hold_d;
  logic [1:0]  type_q, type_d;
  logic [23:0] addr_q, addr_d;
  logic [8:0]  len_q, len_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic [7:0]  status_q, status_d;
  logic        fin_err_q, fin_err_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  logic        op_state;
  logic        accept;
  logic        bad_req;
  logic        read_main;
  logic [15:0] poll_next;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_state  = (state_q == S_WREN) || (state_q == S_MAIN) || (state_q == S_POLL);
    accept    = i_cmd_valid && ready_q;
    bad_req   = (i_cmd_type == 2'd3) || ((i_cmd_type != T_SE) && (i_cmd_len == 9'd0));
    read_main = (state_q == S_MAIN) && (type_q == T_READ);
    poll_next = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

    state_d    = state_q;
    wait_d     = wait_q;
    hold_d     = hold_q;
    type_d     = type_q;
    addr_d     = addr_q;
    len_d      = len_q;
    poll_cnt_d = poll_cnt_q;
    status_d   = status_q;
    fin_err_d  = fin_err_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ready_d    = ready_q;

    if (accept) begin
      ready_d = 1'b0;
    end else if (done_q) begin
      ready_d = 1'b1;
    end

    if (read_main && i_spi_read_valid) begin
      rd_valid_d = 1'b1;
      rd_data_d  = i_spi_read_data;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d     = i_cmd_type;
          addr_d     = i_cmd_addr;
          len_d      = i_cmd_len;
          poll_cnt_d = 16'd0;
          fin_err_d  = bad_req;
          wait_d     = 1'b0;
          if (bad_req)                   state_d = S_FIN;
          else if (i_cmd_type == T_READ) state_d = S_MAIN;
          else                           state_d = S_WREN;
        end
      end
      S_WREN, S_MAIN, S_POLL: begin
        if ((state_q == S_POLL) && i_spi_read_valid) begin
          status_d = i_spi_read_data;
        end
        if (!wait_q) begin
          if (i_spi_op_ready) begin
            wait_d = 1'b1;
            hold_d = 2'd2;
          end
        end else if (hold_q != 2'd0) begin
          // The driver may still show ready right after the handshake.
          hold_d = hold_q - 2'd1;
        end else if (i_spi_op_ready) begin
          wait_d = 1'b0;
          case (state_q)
            S_WREN:  state_d = S_MAIN;
            S_MAIN:  state_d = (type_q == T_READ) ? S_FIN : S_POLL;
            default: state_d = S_CHK;
          endcase
        end
      end
      S_CHK: begin
        if (!status_q[0]) begin
          fin_err_d = 1'b0;
          state_d   = S_FIN;
        end else begin
          poll_cnt_d = poll_next;
          if (poll_next == P_POLL_MAX) begin
            fin_err_d = 1'b1;
            state_d   = S_FIN;
          end else begin
            state_d = S_POLL;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        err_d   = fin_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_spi_op_valid = op_state && !wait_q;
    o_spi_op_data  = 32'd0;
    o_spi_op_len   = 1'b0;
    o_spi_op_type  = 2'd0;
    o_spi_rw_len   = 9'd0;
    case (state_q)
      S_WREN: o_spi_op_data = {P_CMD_WREN, 24'd0};
      S_MAIN: begin
        o_spi_op_len = 1'b1;
        case (type_q)
          T_READ: begin
            o_spi_op_data = {P_CMD_READ, addr_q};
            o_spi_op_type = 2'd1;
            o_spi_rw_len  = len_q;
          end
          T_PP: begin
            o_spi_op_data = {P_CMD_PP, addr_q};
            o_spi_op_type = 2'd2;
            o_spi_rw_len  = len_q;
          end
          default: o_spi_op_data = {P_CMD_SE, addr_q};
        endcase
      end
      S_POLL: begin
        o_spi_op_data = {P_CMD_RDSR, 24'd0};
        o_spi_op_type = 2'd1;
        o_spi_rw_len  = 9'd1;
      end
      default: ;
    endcase
  end

  assign o_wr_req         = (state_q == S_MAIN) && (type_q == T_PP) && i_spi_write_req;
  assign o_spi_write_data = i_wr_data;
  assign o_cmd_ready      = ready_q;
  assign o_done           = done_q;
  assign o_err            = err_q;
  assign o_rd_data        = rd_data_q;
  assign o_rd_valid       = rd_valid_q;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      wait_q     <= 1'b0;
      hold_q     <= 2'd0;
      type_q     <= 2'd0;
      addr_q     <= 24'd0;
      len_q      <= 9'd0;
      poll_cnt_q <= 16'd0;
      status_q   <= 8'd0;
      fin_err_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      rd_data_q  <= 8'd0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      poll_cnt_q <= poll_cnt_d;
      status_q   <= status_d;
      fin_err_q  <= fin_err_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: a behavioural SPI driver, a request-level
// expectation model (op list, read bytes, completion status) and one compare process.
module tb_flash_ctrl;

  localparam logic [15:0] POLL_MAX = 16'd4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd_type;
  logic [23:0] i_cmd_addr;
  logic [8:0]  i_cmd_len;
  logic        o_cmd_ready;
  logic        o_done;
  logic        o_err;
  logic [7:0]  i_wr_data;
  logic        o_wr_req;
  logic [7:0]  o_rd_data;
  logic        o_rd_valid;
  logic [31:0] o_spi_op_data;
  logic        o_spi_op_len;
  logic [1:0]  o_spi_op_type;
  logic        o_spi_op_valid;
  logic        i_spi_op_ready;
  logic [8:0]  o_spi_rw_len;
  logic        i_spi_write_req;
  logic [7:0]  o_spi_write_data;
  logic [7:0]  i_spi_read_data;
  logic        i_spi_read_valid;

  flash_ctrl #(.P_POLL_MAX(POLL_MAX)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .i_cmd_type(i_cmd_type), .i_cmd_addr(i_cmd_addr),
    .i_cmd_len(i_cmd_len), .o_cmd_ready(o_cmd_ready), .o_done(o_done), .o_err(o_err),
    .i_wr_data(i_wr_data), .o_wr_req(o_wr_req), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_spi_op_data(o_spi_op_data), .o_spi_op_len(o_spi_op_len), .o_spi_op_type(o_spi_op_type),
    .o_spi_op_valid(o_spi_op_valid), .i_spi_op_ready(i_spi_op_ready), .o_spi_rw_len(o_spi_rw_len),
    .i_spi_write_req(i_spi_write_req), .o_spi_write_data(o_spi_write_data),
    .i_spi_read_data(i_spi_read_data), .i_spi_read_valid(i_spi_read_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic        len;
    logic [1:0]  typ;
    logic [8:0]  rw;
  } op_t;

  op_t        exp_op_q[$];
  logic       exp_done_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] drv_rd_q[$];
  logic [7:0] drv_stat_q[$];

  int total = 0;
  int bad = 0;
  int hs_cnt = 0, done_cnt = 0, rd_cnt = 0, wr_req_cnt = 0, wr_seen = 0, rdsr_cnt = 0;
  logic [31:0] last_op_data = 32'd0;
  logic [7:0]  last_rd = 8'd0;
  logic        last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
  endtask

  function automatic logic [7:0] wr_pat(input int k);
    logic [31:0] kk;
    kk = k;
    return kk[7:0] ^ 8'h5A;
  endfunction

  function automatic op_t mk_op(input logic [31:0] d, input logic l, input logic [1:0] t,
                                input logic [8:0] rw);
    op_t o;
    o.data = d;
    o.len  = l;
    o.typ  = t;
    o.rw   = rw;
    return o;
  endfunction

  // Request-level model: what the driver must see and how the request ends,
  // given the bytes the driver is about to return.
  task automatic model_req(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l);
    logic [7:0] s;
    logic       e;
    if (t == 2'd3 || (t != 2'd2 && l == 9'd0)) begin
      exp_done_q.push_back(1'b1);
      return;
    end
    if (t == 2'd0) begin
      exp_op_q.push_back(mk_op({8'h03, a}, 1'b1, 2'd1, l));
      foreach (drv_rd_q[i]) exp_rd_q.push_back(drv_rd_q[i]);
      exp_done_q.push_back(1'b0);
      return;
    end
    exp_op_q.push_back(mk_op(32'h0600_0000, 1'b0, 2'd0, 9'd0));
    if (t == 2'd1) exp_op_q.push_back(mk_op({8'h02, a}, 1'b1, 2'd2, l));
    else           exp_op_q.push_back(mk_op({8'h20, a}, 1'b1, 2'd0, 9'd0));
    e = 1'b1;
    for (int i = 0; i < int'(POLL_MAX); i++) begin
      exp_op_q.push_back(mk_op(32'h0500_0000, 1'b0, 2'd1, 9'd1));
      s = (i < drv_stat_q.size()) ? drv_stat_q[i] : 8'h01;
      if (!s[0]) begin
        e = 1'b0;
        break;
      end
    end
    exp_done_q.push_back(e);
  endtask

  // Behavioural SPI driver: keeps ready high one extra cycle after a handshake,
  // then drops it for the data phase and raises it when the op is complete.
  initial begin : spi_drv
    int phase;
    int remain;
    logic [1:0] kind;
    logic rdsr;
    phase = 0;
    remain = 0;
    kind = 2'd0;
    rdsr = 1'b0;
    i_spi_op_ready   = 1'b1;
    i_spi_write_req  = 1'b0;
    i_spi_read_valid = 1'b0;
    i_spi_read_data  = 8'd0;
    forever begin
      @(negedge i_clk);
      i_spi_write_req  = 1'b0;
      i_spi_read_valid = 1'b0;
      if (i_rst) begin
        phase = 0;
        i_spi_op_ready = 1'b1;
      end else begin
        case (phase)
          0: if (o_spi_op_valid && i_spi_op_ready) begin
               kind   = o_spi_op_type;
               rdsr   = (o_spi_op_data[31:24] == 8'h05);
               remain = (kind == 2'd0) ? 0 : int'(o_spi_rw_len);
               phase  = 1;
             end
          1: phase = 2;
          2: begin
               i_spi_op_ready = 1'b0;
               phase = 3;
             end
          default: begin
            if (remain > 0) begin
              remain--;
              if (kind == 2'd2) begin
                i_spi_write_req = 1'b1;
              end else begin
                i_spi_read_valid = 1'b1;
                if (rdsr) begin
                  if (drv_stat_q.size() > 0) i_spi_read_data = drv_stat_q.pop_front();
                  else                       i_spi_read_data = 8'h01;
                end else begin
                  if (drv_rd_q.size() > 0) i_spi_read_data = drv_rd_q.pop_front();
                  else                     i_spi_read_data = 8'hEE;
                end
              end
            end else begin
              i_spi_op_ready = 1'b1;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // User side: supplies program byte k as wr_pat(k), advancing on each o_wr_req.
  initial begin : user_side
    int idx;
    idx = 0;
    i_wr_data = wr_pat(0);
    forever begin
      @(negedge i_clk);
      #3;
      if (o_wr_req) begin
        idx++;
        i_wr_data = wr_pat(idx);
      end
    end
  end

  // Compare process.
  always @(negedge i_clk) begin : mon
    op_t e;
    #2;
    if (!i_rst) begin
      if (o_spi_op_valid && exp_op_q.size() == 0) begin
        fail_now("stray_op_valid", o_spi_op_data);
      end else if (o_spi_op_valid && i_spi_op_ready) begin
        hs_cnt++;
        last_op_data = o_spi_op_data;
        if (o_spi_op_data[31:24] == 8'h05) rdsr_cnt++;
        e = exp_op_q.pop_front();
        check("op_data", o_spi_op_data, e.data);
        check("op_len", {31'd0, o_spi_op_len}, {31'd0, e.len});
        check("op_type", {30'd0, o_spi_op_type}, {30'd0, e.typ});
        if (e.typ != 2'd0) check("op_rw_len", {23'd0, o_spi_rw_len}, {23'd0, e.rw});
      end
      if (o_rd_valid) begin
        rd_cnt++;
        last_rd = o_rd_data;
        if (exp_rd_q.size() == 0) fail_now("stray_rd_valid", {24'd0, o_rd_data});
        else check("rd_data", {24'd0, o_rd_data}, {24'd0, exp_rd_q.pop_front()});
      end
      if (i_spi_write_req) begin
        check("wr_req_follow", {31'd0, o_wr_req}, 32'd1);
        check("wr_data", {24'd0, o_spi_write_data}, {24'd0, wr_pat(wr_seen)});
        wr_seen++;
      end
      if (o_wr_req) begin
        wr_req_cnt++;
        if (!i_spi_write_req) fail_now("wr_req_unprompted", 32'd1);
      end
      if (o_done) begin
        done_cnt++;
        last_err = o_err;
        if (exp_done_q.size() == 0) fail_now("stray_done", {31'd0, o_err});
        else check("done_err", {31'd0, o_err}, {31'd0, exp_done_q.pop_front()});
        check("rd_drained", exp_rd_q.size(), 32'd0);
      end
      if (o_err && !o_done) fail_now("err_without_done", 32'd1);
    end
  end

  task automatic send(input logic [1:0] t, input logic [23:0] a, input logic [8:0] l);
    int g;
    g = 0;
    while (!o_cmd_ready && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    if (!o_cmd_ready) fail_now("ready_timeout", 32'd0);
    i_cmd_type  = t;
    i_cmd_addr  = a;
    i_cmd_len   = l;
    i_cmd_valid = 1'b1;
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int g;
    g = 0;
    while (done_cnt == d0 && g < budget) begin
      @(negedge i_clk);
      #3;
      g++;
    end
    if (done_cnt == d0) fail_now("done_timeout", g);
    @(negedge i_clk);
  endtask

  initial begin : main
    int h0, d0, r0, w0, p0, g;
    i_rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_type = 2'd0;
    i_cmd_addr = 24'd0;
    i_cmd_len = 9'd0;
    repeat (3) @(negedge i_clk);
    check("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_op_valid", {31'd0, o_spi_op_valid}, 32'd0);
    check("rst_rd_valid", {31'd0, o_rd_valid}, 32'd0);
    check("rst_op_data", o_spi_op_data, 32'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    // Read of four bytes.
    drv_rd_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    model_req(2'd0, 24'h012345, 9'd4);
    h0 = hs_cnt; d0 = done_cnt; r0 = rd_cnt;
    send(2'd0, 24'h012345, 9'd4);
    wait_done(d0, 200);
    check("read_ops", hs_cnt - h0, 32'd1);
    check("read_op_data", last_op_data, 32'h0301_2345);
    check("read_bytes", rd_cnt - r0, 32'd4);
    check("read_last_byte", {24'd0, last_rd}, 32'h0000_00D4);
    check("read_err", {31'd0, last_err}, 32'd0);
    check("read_ready_back", {31'd0, o_cmd_ready}, 32'd1);

    // Page program of 256 bytes, with a request arriving while busy.
    drv_stat_q = '{8'h01, 8'h01, 8'h00};
    model_req(2'd1, 24'h000100, 9'd256);
    h0 = hs_cnt; d0 = done_cnt; w0 = wr_req_cnt; p0 = rdsr_cnt;
    send(2'd1, 24'h000100, 9'd256);
    g = 0;
    while (hs_cnt < h0 + 2 && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    check("pp_main_reached", hs_cnt - h0, 32'd2);
    check("pp_main_op", last_op_data, 32'h0200_0100);
    check("busy_ready_low", {31'd0, o_cmd_ready}, 32'd0);
    i_cmd_type = 2'd0; i_cmd_addr = 24'h00ABCD; i_cmd_len = 9'd4; i_cmd_valid = 1'b1;
    repeat (3) @(negedge i_clk);
    i_cmd_valid = 1'b0;
    wait_done(d0, 2000);
    check("pp_ops", hs_cnt - h0, 32'd5);
    check("pp_wr_reqs", wr_req_cnt - w0, 32'd256);
    check("pp_polls", rdsr_cnt - p0, 32'd3);
    check("pp_err", {31'd0, last_err}, 32'd0);

    // Sector erase with the status stuck busy: poll timeout.
    drv_stat_q.delete();
    model_req(2'd2, 24'h0ABCDE, 9'd0);
    h0 = hs_cnt; d0 = done_cnt; p0 = rdsr_cnt;
    send(2'd2, 24'h0ABCDE, 9'd0);
    wait_done(d0, 500);
    check("se_ops", hs_cnt - h0, 32'd6);
    check("se_polls", rdsr_cnt - p0, 32'd4);
    check("se_err", {31'd0, last_err}, 32'd1);

    // Rejected requests: reserved type, then zero-length read.
    for (int k = 0; k < 2; k++) begin
      h0 = hs_cnt;
      if (k == 0) begin
        model_req(2'd3, 24'h000010, 9'd5);
        send(2'd3, 24'h000010, 9'd5);
      end else begin
        model_req(2'd0, 24'h000020, 9'd0);
        send(2'd0, 24'h000020, 9'd0);
      end
      check("rej_ready_low", {31'd0, o_cmd_ready}, 32'd0);
      check("rej_done_early", {31'd0, o_done}, 32'd0);
      @(negedge i_clk);
      check("rej_done", {31'd0, o_done}, 32'd1);
      check("rej_err", {31'd0, o_err}, 32'd1);
      @(negedge i_clk);
      check("rej_ready_back", {31'd0, o_cmd_ready}, 32'd1);
      check("rej_done_pulse", {31'd0, o_done}, 32'd0);
      check("rej_no_ops", hs_cnt - h0, 32'd0);
    end

    // Reset during the POLL wait, then a fresh read.
    drv_stat_q.delete();
    model_req(2'd2, 24'h001000, 9'd0);
    p0 = rdsr_cnt;
    send(2'd2, 24'h001000, 9'd0);
    g = 0;
    while (rdsr_cnt == p0 && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    check("rst_poll_reached", rdsr_cnt - p0, 32'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    exp_op_q.delete();
    exp_done_q.delete();
    @(negedge i_clk);
    check("midrst_ready", {31'd0, o_cmd_ready}, 32'd1);
    check("midrst_op_valid", {31'd0, o_spi_op_valid}, 32'd0);
    check("midrst_done", {31'd0, o_done}, 32'd0);
    d0 = done_cnt;
    i_rst = 1'b0;
    repeat (10) @(negedge i_clk);
    check("midrst_no_done", done_cnt - d0, 32'd0);
    drv_rd_q = '{8'h11, 8'h22};
    model_req(2'd0, 24'hFFFFFE, 9'd2);
    h0 = hs_cnt; d0 = done_cnt; r0 = rd_cnt;
    send(2'd0, 24'hFFFFFE, 9'd2);
    wait_done(d0, 200);
    check("post_rst_op", last_op_data, 32'h03FF_FFFE);
    check("post_rst_ops", hs_cnt - h0, 32'd1);
    check("post_rst_bytes", rd_cnt - r0, 32'd2);
    check("post_rst_last", {24'd0, last_rd}, 32'h0000_0022);

    repeat (3) @(negedge i_clk);
    check("ops_drained", exp_op_q.size(), 32'd0);
    check("dones_drained", exp_done_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/flash_ctrl.md
Name: flash_ctrl

Overview:
Command sequencer that sits between user logic and the SPI flash driver (single runtime-typed driver instance). It turns one user request (read, page program, sector erase) into an ordered series of SPI operations: WREN, the main command, then RDSR polling until WIP clears. Write data passes from user to driver, and read data passes from driver to user. There is one outstanding request at a time.

Parameters:
P_POLL_MAX, 16'd50000, maximum RDSR polls before timeout error
P_CMD_READ, 8'h03, read opcode
P_CMD_PP, 8'h02, page program opcode
P_CMD_SE, 8'h20, sector erase opcode
P_CMD_WREN, 8'h06, write enable opcode
P_CMD_RDSR, 8'h05, read status opcode

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous reset, active-high
i_cmd_valid  in  1  user request valid
i_cmd_type  in  2  0 read, 1 page program, 2 sector erase, 3 reserved
i_cmd_addr  in  24  flash byte address
i_cmd_len  in  9  byte count 1..256 (read/program)
o_cmd_ready  out  1  controller idle, accepts request
o_done  out  1  one-cycle pulse, request finished
o_err  out  1  valid with o_done; bad request or poll timeout
i_wr_data  in  8  program byte from user
o_wr_req  out  1  request next program byte
o_rd_data  out  8  read byte to user
o_rd_valid  out  1  o_rd_data valid
o_spi_op_data  out  32  {opcode, addr} or {opcode, 24'd0}
o_spi_op_len  out  1  0 = 8-bit op, 1 = 32-bit op
o_spi_op_type  out  2  0 cmd only, 1 cmd+read, 2 cmd+write
o_spi_op_valid  out  1  op request to driver
i_spi_op_ready  in  1  driver idle
o_spi_rw_len  out  9  data bytes for driver
i_spi_write_req  in  1  driver requests write byte
o_spi_write_data  out  8  byte to driver
i_spi_read_data  in  8  byte from driver
i_spi_read_valid  in  1  driver byte valid

Behaviour:
- Reset values: all outputs 0 except o_cmd_ready=1. State goes to IDLE. Reset mid-operation abandons the op immediately with no o_done.
- Accept: i_cmd_valid & o_cmd_ready. Latch type, addr and len. o_cmd_ready drops the next cycle and returns high on the cycle after o_done.
- Reject: type 3, or len 0 for read/program. No SPI op is issued. o_done=o_err=1 two cycles after accept.
- States: IDLE, WREN, MAIN, POLL, CHK, FIN. Each op state has an ISSUE and a WAIT substate.
- ISSUE: drive op fields and hold o_spi_op_valid until the cycle i_spi_op_ready=1, then drop valid.
- WAIT: ignore ready for 2 cycles after handshake. Then the first i_spi_op_ready=1 means the op is complete.
- Read: MAIN = {P_CMD_READ, addr}, len=1, type=1, rw_len=len, then FIN. No WREN, no poll.
- Program: WREN ({P_CMD_WREN,24'd0}, len=0, type=0), then MAIN ({P_CMD_PP,addr}, len=1, type=2, rw_len=len), then POLL.
- Erase: WREN, then MAIN ({P_CMD_SE,addr}, type=0), then POLL.
- POLL: {P_CMD_RDSR,24'd0}, len=0, type=1, rw_len=1. Capture the status byte on i_spi_read_valid.
- CHK: if status[0]=0, go to FIN with err=0. Else increment the poll counter. If counter equals P_POLL_MAX, go to FIN with err=1; otherwise return to POLL.
- Poll counter is 16-bit, cleared on accept, and does not wrap.
- FIN: o_done pulse for 1 cycle, then IDLE.
- o_wr_req = i_spi_write_req only during program MAIN; 0 otherwise.
- o_spi_write_data = i_wr_data, combinational.
- o_rd_data/o_rd_valid register i_spi_read_data/valid (1-cycle latency), only during read MAIN. Status bytes are never forwarded.
- i_cmd_valid while busy is ignored and not queued.
- Page wrap within 256 B is the flash's concern; addr passes through unchanged.

Test Plan:
- Read: type=0, addr=0x012345, len=4, driver returns A1 B2 C3 D4 -> one op, op_data=0x03012345, rw_len=4, four o_rd_valid with those bytes, then o_done, err=0.
- Program: type=1, addr=0x000100, len=256 -> ops in order 0x06000000 (len0), 0x02000100 (type2, rw_len256), then RDSR. 256 o_wr_req pulses. Status 01,01,00 -> 3 polls, o_done err=0.
- Erase with timeout: P_POLL_MAX=4, status stuck 0x01 -> WREN, 0x20xxxxxx, exactly 4 RDSR ops, o_done with o_err=1.
- Bad request: type=3, or type=0 with len=0 -> no o_spi_op_valid, o_done+o_err after 2 cycles, ready restored.
- Busy ignore: assert i_cmd_valid during program MAIN -> no second accept, no extra ops.
- Reset: assert i_rst during the POLL wait -> o_cmd_ready=1, o_spi_op_valid=0, no o_done. A new read then completes normally.
